// File: rtl/seq_alu.sv
// Handshaked RV32I execute-stage ALU: 1-cycle integer ops plus iterative
// shift-add multiply and restoring unsigned divide over DATA_WIDTH cycles.
module seq_alu #(
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CTRL_WIDTH-1:0] ALUctrl,
  input  logic [DATA_WIDTH-1:0] ALUop1,
  input  logic [DATA_WIDTH-1:0] ALUop2,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] ALUResult,
  output logic                  Zero,
  output logic                  busy
);

  // Handshake: a request transfers on a rising edge where in_valid && in_ready;
  // a result transfers on a rising edge where out_valid && out_ready. A producer
  // must hold its payload stable until the transfer edge.

  localparam int W     = DATA_WIDTH;
  localparam int SH_W  = $clog2(DATA_WIDTH);
  localparam int CNT_W = SH_W + 1;

  localparam logic [CTRL_WIDTH-1:0] OP_ADD   = CTRL_WIDTH'(0);
  localparam logic [CTRL_WIDTH-1:0] OP_SUB   = CTRL_WIDTH'(1);
  localparam logic [CTRL_WIDTH-1:0] OP_AND   = CTRL_WIDTH'(2);
  localparam logic [CTRL_WIDTH-1:0] OP_OR    = CTRL_WIDTH'(3);
  localparam logic [CTRL_WIDTH-1:0] OP_XOR   = CTRL_WIDTH'(4);
  localparam logic [CTRL_WIDTH-1:0] OP_SLL   = CTRL_WIDTH'(5);
  localparam logic [CTRL_WIDTH-1:0] OP_SRL   = CTRL_WIDTH'(6);
  localparam logic [CTRL_WIDTH-1:0] OP_SRA   = CTRL_WIDTH'(7);
  localparam logic [CTRL_WIDTH-1:0] OP_SLT   = CTRL_WIDTH'(8);
  localparam logic [CTRL_WIDTH-1:0] OP_SLTU  = CTRL_WIDTH'(9);
  localparam logic [CTRL_WIDTH-1:0] OP_MUL   = CTRL_WIDTH'(10);
  localparam logic [CTRL_WIDTH-1:0] OP_MULHU = CTRL_WIDTH'(11);
  localparam logic [CTRL_WIDTH-1:0] OP_DIVU  = CTRL_WIDTH'(12);
  localparam logic [CTRL_WIDTH-1:0] OP_REMU  = CTRL_WIDTH'(13);

  typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN, DONE} state_t;

  state_t                state_q;
  logic [CTRL_WIDTH-1:0] op_q;
  logic [2*W-1:0]        acc_q;
  logic [W-1:0]          opb_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [W-1:0]          result_q;
  logic                  zero_q;

  logic [SH_W-1:0] shamt;
  logic [W-1:0]    alu_res;
  logic            is_mul, is_div;
  logic [W:0]      mul_sum;
  logic [2*W-1:0]  mul_next;
  logic [W:0]      rem_sh;
  logic [W:0]      div_sub;
  logic [2*W-1:0]  div_next;
  logic [2*W-1:0]  step_next;
  logic            hi_sel;
  logic [W-1:0]    final_res;

  assign shamt  = ALUop2[SH_W-1:0];
  assign is_mul = (ALUctrl == OP_MUL) || (ALUctrl == OP_MULHU);
  assign is_div = ((ALUctrl == OP_DIVU) || (ALUctrl == OP_REMU)) && (ALUop2 != '0);

  // DIVU/REMU entries only matter for a zero divisor; otherwise they iterate.
  always_comb begin
    alu_res = '0;
    case (ALUctrl)
      OP_ADD:  alu_res = ALUop1 + ALUop2;
      OP_SUB:  alu_res = ALUop1 - ALUop2;
      OP_AND:  alu_res = ALUop1 & ALUop2;
      OP_OR:   alu_res = ALUop1 | ALUop2;
      OP_XOR:  alu_res = ALUop1 ^ ALUop2;
      OP_SLL:  alu_res = ALUop1 << shamt;
      OP_SRL:  alu_res = ALUop1 >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(ALUop1) >>> shamt);
      OP_SLT:  alu_res = {{(W-1){1'b0}}, ($signed(ALUop1) < $signed(ALUop2))};
      OP_SLTU: alu_res = {{(W-1){1'b0}}, (ALUop1 < ALUop2)};
      OP_DIVU: alu_res = '1;
      OP_REMU: alu_res = ALUop1;
      default: alu_res = '0;
    endcase
  end

  // acc_q holds {partial product, multiplier} for MUL and {remainder, quotient} for DIV.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opb_q} : {(W+1){1'b0}});
    mul_next = {mul_sum, acc_q[W-1:1]};
    rem_sh   = {acc_q[2*W-1:W], acc_q[W-1]};
    div_sub  = rem_sh - {1'b0, opb_q};
    if (rem_sh >= {1'b0, opb_q}) begin
      div_next = {div_sub[W-1:0], acc_q[W-2:0], 1'b1};
    end else begin
      div_next = {rem_sh[W-1:0], acc_q[W-2:0], 1'b0};
    end
    step_next = (state_q == MUL_RUN) ? mul_next : div_next;
    hi_sel    = (op_q == OP_MULHU) || (op_q == OP_REMU);
    final_res = hi_sel ? step_next[2*W-1:W] : step_next[W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            op_q <= ALUctrl;
            if (is_mul) begin
              acc_q   <= {{W{1'b0}}, ALUop2};
              opb_q   <= ALUop1;
              cnt_q   <= CNT_W'(W);
              state_q <= MUL_RUN;
            end else if (is_div) begin
              acc_q   <= {{W{1'b0}}, ALUop1};
              opb_q   <= ALUop2;
              cnt_q   <= CNT_W'(W);
              state_q <= DIV_RUN;
            end else begin
              result_q <= alu_res;
              zero_q   <= (alu_res == '0);
              state_q  <= DONE;
            end
          end
        end
        MUL_RUN, DIV_RUN: begin
          acc_q <= step_next;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            result_q <= final_res;
            zero_q   <= (final_res == '0);
            state_q  <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == MUL_RUN) || (state_q == DIV_RUN);
  assign ALUResult = result_q;
  assign Zero      = zero_q;

endmodule
